fp_cmp_pipe: RTL and testbench

FP_CMP_PIPE -- requirements
Module: fp_cmp_pipe

---
 rtl/fp_pkg.sv | 21 ++
 rtl/fp_classify.sv | 29 ++
 rtl/fp_cmp_pipe.sv | 202 ++++++++++++++++++++
 tb/tb_fp_cmp_pipe.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared op encodings and format helpers
// for the floating-point compare pipeline.
package fp_pkg;

  localparam logic [2:0] OP_EQ  = 3'd0;
  localparam logic [2:0] OP_LT  = 3'd1;
  localparam logic [2:0] OP_LE  = 3'd2;
  localparam logic [2:0] OP_MIN = 3'd3;
  localparam logic [2:0] OP_MAX = 3'd4;

  // Canonical quiet NaN, right-aligned in 64 bits.
  function automatic logic [63:0] fp_qnan(
    input int exp_w,
    input int man_w
  );
    logic [63:0] ones;
    ones = (64'd1 << exp_w) - 64'd1;
    return (ones << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_classify.sv
// fp_classify: decodes an operand magnitude
// into NaN / sNaN / zero / infinity flags.
module fp_classify #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W-1:0] x,
  output logic                   is_nan,
  output logic                   is_snan,
  output logic                   is_zero,
  output logic                   is_inf
);

  logic [EXP_W-1:0] e;
  logic [MAN_W-1:0] m;
  logic             e_ones;
  logic             m_nz;

  assign e      = x[MAN_W +: EXP_W];
  assign m      = x[MAN_W-1:0];
  assign e_ones = &e;
  assign m_nz   = |m;

  assign is_nan  = e_ones && m_nz;
  assign is_snan = is_nan && !m[MAN_W-1];
  assign is_zero = (e == '0) && !m_nz;
  assign is_inf  = e_ones && !m_nz;

endmodule

// File: rtl/fp_cmp_pipe.sv
// fp_cmp_pipe: two-stage IEEE-754 compare/min/max
// with valid/ready flow control on both sides.
module fp_cmp_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic [2:0]           op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 lt,
  output logic                 eq,
  output logic                 gt,
  output logic                 unord,
  output logic [EXP_W+MAN_W:0] res,
  output logic                 inv,
  output logic                 inv_sticky,
  input  logic                 flag_clr
);

  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [63:0] QNAN64 = fp_qnan(EXP_W, MAN_W);
  localparam logic [W-1:0] QNAN = QNAN64[W-1:0];

  // class bundles: {nan, snan, zero, inf}
  logic [3:0] ca_c, cb_c;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
    .x       (a[W-2:0]),
    .is_nan  (ca_c[3]),
    .is_snan (ca_c[2]),
    .is_zero (ca_c[1]),
    .is_inf  (ca_c[0])
  );

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
    .x       (b[W-2:0]),
    .is_nan  (cb_c[3]),
    .is_snan (cb_c[2]),
    .is_zero (cb_c[1]),
    .is_inf  (cb_c[0])
  );

  logic           s1_v_q, s1_v_d;
  logic [W-1:0]   s1_a_q, s1_b_q;
  logic [2:0]     s1_op_q;
  logic [3:0]     s1_ca_q, s1_cb_q;

  logic           ov_q, ov_d;
  logic           lt_q, eq_q, gt_q, unord_q;
  logic [W-1:0]   res_q;
  logic           inv_q;
  logic           stk_q, stk_d;

  logic s2_adv, s1_adv, in_fire, out_fire;

  assign s2_adv   = !ov_q || out_ready;
  assign s1_adv   = s1_v_q && s2_adv;
  assign in_ready = !s1_v_q || s2_adv;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = ov_q && out_ready;

  assign s1_v_d = in_fire || (s1_v_q && !s2_adv);
  assign ov_d   = s1_adv || (ov_q && !out_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v_q  <= 1'b0;
      s1_a_q  <= '0;
      s1_b_q  <= '0;
      s1_op_q <= '0;
      s1_ca_q <= '0;
      s1_cb_q <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      if (in_fire) begin
        s1_a_q  <= a;
        s1_b_q  <= b;
        s1_op_q <= op;
        s1_ca_q <= ca_c;
        s1_cb_q <= cb_c;
      end
    end
  end

  logic         sa, sb, nan_a, nan_b;
  logic         nan_any, snan_any, both_zero, both_inf;
  logic         mag_lt, mag_eq;
  logic         lt_c, eq_c, gt_c;
  logic [W-1:0] min_c, max_c, res_d;
  logic         inv_d;
  logic         is_lt, is_le, is_min, is_max, is_rsv;

  assign sa        = s1_a_q[W-1];
  assign sb        = s1_b_q[W-1];
  assign nan_a     = s1_ca_q[3];
  assign nan_b     = s1_cb_q[3];
  assign nan_any   = nan_a || nan_b;
  assign snan_any  = s1_ca_q[2] || s1_cb_q[2];
  assign both_zero = s1_ca_q[1] && s1_cb_q[1];
  assign both_inf  = s1_ca_q[0] && s1_cb_q[0];
  assign mag_lt    = s1_a_q[W-2:0] < s1_b_q[W-2:0];
  assign mag_eq    = s1_a_q[W-2:0] == s1_b_q[W-2:0];

  // Signed zeros compare equal; same-sign negatives flip magnitude order.
  assign eq_c = !nan_any && (both_zero ||
                (sa == sb && (mag_eq || both_inf)));
  assign lt_c = !nan_any && !eq_c &&
                ((sa && !sb) ||
                 (!sa && !sb && mag_lt) ||
                 (sa && sb && !mag_lt && !mag_eq));
  assign gt_c = !nan_any && !eq_c && !lt_c;

  always_comb begin
    min_c = lt_c ? s1_a_q : s1_b_q;
    max_c = gt_c ? s1_a_q : s1_b_q;
    if (nan_a && nan_b) begin
      min_c = QNAN;
      max_c = QNAN;
    end else if (nan_a) begin
      min_c = s1_b_q;
      max_c = s1_b_q;
    end else if (nan_b) begin
      min_c = s1_a_q;
      max_c = s1_a_q;
    end else if (both_zero) begin
      min_c = sa ? s1_a_q : s1_b_q;
      max_c = sa ? s1_b_q : s1_a_q;
    end
  end

  assign is_lt  = s1_op_q == OP_LT;
  assign is_le  = s1_op_q == OP_LE;
  assign is_min = s1_op_q == OP_MIN;
  assign is_max = s1_op_q == OP_MAX;
  assign is_rsv = s1_op_q > OP_MAX;

  always_comb begin
    res_d = '0;
    inv_d = snan_any;
    unique case (1'b1)
      is_lt: begin
        res_d[0] = lt_c;
        inv_d    = nan_any;
      end
      is_le: begin
        res_d[0] = lt_c || eq_c;
        inv_d    = nan_any;
      end
      is_min: res_d = min_c;
      is_max: res_d = max_c;
      default: begin
        res_d[0] = eq_c;
        inv_d    = snan_any || is_rsv;
      end
    endcase
  end

  assign stk_d = (out_fire && inv_q) ? 1'b1 :
                 flag_clr ? 1'b0 : stk_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ov_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      unord_q <= 1'b0;
      res_q   <= '0;
      inv_q   <= 1'b0;
      stk_q   <= 1'b0;
    end else begin
      ov_q  <= ov_d;
      stk_q <= stk_d;
      if (s1_adv) begin
        lt_q    <= lt_c;
        eq_q    <= eq_c;
        gt_q    <= gt_c;
        unord_q <= nan_any;
        res_q   <= res_d;
        inv_q   <= inv_d;
      end
    end
  end

  assign out_valid  = ov_q;
  assign lt         = lt_q;
  assign eq         = eq_q;
  assign gt         = gt_q;
  assign unord      = unord_q;
  assign res        = res_q;
  assign inv        = inv_q;
  assign inv_sticky = stk_q;

endmodule

// File: tb/tb_fp_cmp_pipe.sv
// tb_fp_cmp_pipe: directed vectors on single and half
// precision instances plus flow-control corner sequences.
module tb_fp_cmp_pipe;
  import fp_pkg::*;

  localparam logic [3:0] O_LT = 4'b1000;
  localparam logic [3:0] O_EQ = 4'b0100;
  localparam logic [3:0] O_GT = 4'b0010;
  localparam logic [3:0] O_UN = 4'b0001;

  typedef struct {
    logic        half;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ord;
    logic [31:0] res;
    logic        inv;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        vin, irdy, ov, ordy, lt_o, eq_o, gt_o, un_o;
  logic        inv_o, stk_o, fclr;
  logic [31:0] a32, b32, res32;
  logic [2:0]  op32;

  logic        vh, irdyh, ovh, ordyh, lth, eqh, gth, unh;
  logic        invh, stkh, fclrh;
  logic [15:0] ah, bh, resh;
  logic [2:0]  oph;

  fp_cmp_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(vin), .in_ready(irdy),
    .a(a32), .b(b32), .op(op32),
    .out_valid(ov), .out_ready(ordy),
    .lt(lt_o), .eq(eq_o), .gt(gt_o), .unord(un_o),
    .res(res32), .inv(inv_o), .inv_sticky(stk_o),
    .flag_clr(fclr)
  );

  fp_cmp_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst),
    .in_valid(vh), .in_ready(irdyh),
    .a(ah), .b(bh), .op(oph),
    .out_valid(ovh), .out_ready(ordyh),
    .lt(lth), .eq(eqh), .gt(gth), .unord(unh),
    .res(resh), .inv(invh), .inv_sticky(stkh),
    .flag_clr(fclrh)
  );

  int total = 0;
  int bad   = 0;
  logic stk_m32 = 1'b0;
  logic stk_m16 = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic        o;
    logic [3:0]  ord_a;
    logic [31:0] res_a;
    logic        inv_a;
    int          n;
    @(negedge clk);
    if (v.half) begin
      vh = 1'b1; ah = v.a[15:0]; bh = v.b[15:0]; oph = v.op;
    end else begin
      vin = 1'b1; a32 = v.a; b32 = v.b; op32 = v.op;
    end
    @(posedge clk);
    #1;
    vin = 1'b0;
    vh  = 1'b0;
    n = 1;
    o = v.half ? ovh : ov;
    while (!o && n < 8) begin
      @(posedge clk);
      #1;
      n++;
      o = v.half ? ovh : ov;
    end
    chk($sformatf("lat[%0d]", idx), n, 2);
    if (v.half) begin
      ord_a = {lth, eqh, gth, unh};
      res_a = {16'h0, resh};
      inv_a = invh;
    end else begin
      ord_a = {lt_o, eq_o, gt_o, un_o};
      res_a = res32;
      inv_a = inv_o;
    end
    chk($sformatf("ord[%0d]", idx), {28'h0, ord_a}, {28'h0, v.ord});
    chk($sformatf("res[%0d]", idx), res_a, v.res);
    chk($sformatf("inv[%0d]", idx), {31'h0, inv_a}, {31'h0, v.inv});
    @(posedge clk);
    #1;
    if (v.half) begin
      stk_m16 = stk_m16 | v.inv;
      chk($sformatf("stk[%0d]", idx), {31'h0, stkh}, {31'h0, stk_m16});
    end else begin
      stk_m32 = stk_m32 | v.inv;
      chk($sformatf("stk[%0d]", idx), {31'h0, stk_o}, {31'h0, stk_m32});
    end
  endtask

  vec_t        vt[20];
  int          nv;
  logic [31:0] vals[8];
  int          idx, got;
  logic        saw_stall, acc, extra;

  initial begin
    vin = 0; a32 = 0; b32 = 0; op32 = 0; ordy = 1; fclr = 0;
    vh = 0; ah = 0; bh = 0; oph = 0; ordyh = 1; fclrh = 0;

    nv = 0;
    vt[nv++] = '{0, OP_EQ,  32'h00000000, 32'h80000000, O_EQ, 32'h1, 0};
    vt[nv++] = '{0, OP_LT,  32'hBF800000, 32'hC0000000, O_GT, 32'h0, 0};
    vt[nv++] = '{0, OP_LT,  32'h7FC00000, 32'h3F800000, O_UN, 32'h0, 1};
    vt[nv++] = '{0, OP_MIN, 32'h7F800001, 32'h3F800000, O_UN, 32'h3F800000, 1};
    vt[nv++] = '{0, OP_MAX, 32'h7FC00000, 32'h7FC00001, O_UN, 32'h7FC00000, 0};
    vt[nv++] = '{0, OP_MIN, 32'h00000000, 32'h80000000, O_EQ, 32'h80000000, 0};
    vt[nv++] = '{0, OP_MAX, 32'h80000000, 32'h00000000, O_EQ, 32'h00000000, 0};
    vt[nv++] = '{0, OP_LE,  32'h7F800000, 32'h7F800000, O_EQ, 32'h1, 0};
    vt[nv++] = '{0, OP_LT,  32'h00000001, 32'h00800000, O_LT, 32'h1, 0};
    vt[nv++] = '{0, OP_EQ,  32'h7F800001, 32'h00000000, O_UN, 32'h0, 1};
    vt[nv++] = '{0, 3'd5,   32'h3F800000, 32'h3F800000, O_EQ, 32'h1, 1};
    vt[nv++] = '{0, OP_LE,  32'hFF800000, 32'h80000000, O_LT, 32'h1, 0};
    vt[nv++] = '{0, OP_EQ,  32'h7FC00000, 32'h7FC00000, O_UN, 32'h0, 0};
    vt[nv++] = '{0, OP_MAX, 32'h3F800000, 32'h40000000, O_LT, 32'h40000000, 0};
    vt[nv++] = '{1, OP_EQ,  32'h0000, 32'h8000, O_EQ, 32'h1, 0};
    vt[nv++] = '{1, OP_LT,  32'hBC00, 32'hC000, O_GT, 32'h0, 0};
    vt[nv++] = '{1, OP_LT,  32'h7E00, 32'h3C00, O_UN, 32'h0, 1};
    vt[nv++] = '{1, OP_MIN, 32'h7C01, 32'h3C00, O_UN, 32'h3C00, 1};
    vt[nv++] = '{1, OP_MAX, 32'h7E00, 32'h7E01, O_UN, 32'h7E00, 0};
    vt[nv++] = '{1, OP_MIN, 32'h0000, 32'h8000, O_EQ, 32'h8000, 0};

    #12;
    chk("rst_ov",   {31'h0, ov},   32'h0);
    chk("rst_ordr", {28'h0, lt_o, eq_o, gt_o, un_o}, 32'h0);
    chk("rst_res",  res32, 32'h0);
    chk("rst_inv",  {30'h0, inv_o, stk_o}, 32'h0);
    chk("rst_irdy", {31'h0, irdy}, 32'h1);
    chk("rst_h",    {29'h0, ovh, stkh, ~irdyh}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < nv; i++) run_vec(i, vt[i]);

    // Back-to-back stream with a three-cycle consumer stall.
    for (int i = 0; i < 8; i++) vals[i] = 32'h3F800000 + i;
    idx = 0; got = 0; saw_stall = 0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(negedge clk);
      vin  = (idx < 8);
      if (idx < 8) a32 = vals[idx];
      b32  = 32'h0;
      op32 = OP_MAX;
      ordy = !(cyc >= 4 && cyc < 7);
      #1;
      if (vin && !irdy) saw_stall = 1'b1;
      if (ov && !ordy) chk("hold", res32, vals[got]);
      if (ov && ordy) begin
        chk($sformatf("stream[%0d]", got), res32, vals[got]);
        got++;
      end
      acc = vin && irdy;
      @(posedge clk);
      if (acc) idx++;
    end
    #1;
    vin = 1'b0; ordy = 1'b1;
    chk("stream_cnt", got, 8);
    chk("irdy_drop", {31'h0, saw_stall}, 32'h1);
    extra = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ov) extra = 1'b1;
    end
    chk("no_dup", {31'h0, extra}, 32'h0);

    // Reset with two operations in flight.
    @(negedge clk);
    ordy = 1'b0; vin = 1'b1; op32 = OP_MAX;
    a32 = 32'h3F800000; b32 = 32'h0;
    @(posedge clk);
    #1;
    a32 = 32'h40000000;
    @(posedge clk);
    #1;
    vin = 1'b0;
    chk("inflight_ov", {31'h0, ov}, 32'h1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_ov", {31'h0, ov}, 32'h0);
    chk("rst_mid_irdy", {31'h0, irdy}, 32'h1);
    stk_m32 = 1'b0;
    stk_m16 = 1'b0;
    chk("rst_mid_stk", {30'h0, stk_o, stkh}, 32'h0);
    @(negedge clk);
    rst = 1'b1; ordy = 1'b1;
    extra = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ov) extra = 1'b1;
    end
    chk("no_stale", {31'h0, extra}, 32'h0);

    // Clear and invalid handshake in the same cycle: set wins.
    @(negedge clk);
    vin = 1'b1; op32 = OP_LT; a32 = 32'h7FC00000; b32 = 32'h0;
    @(posedge clk);
    #1;
    vin = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ov) break;
    end
    chk("clr_inv", {30'h0, ov, inv_o}, 32'h3);
    fclr = 1'b1;
    @(posedge clk);
    #1;
    fclr = 1'b0;
    chk("clr_set_wins", {31'h0, stk_o}, 32'h1);
    @(negedge clk);
    fclr = 1'b1;
    @(posedge clk);
    #1;
    fclr = 1'b0;
    chk("clr_only", {31'h0, stk_o}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
